// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and counter width shared by the VGA sync generator.
package vga_timing_pkg;
  localparam int CNT_W      = 10;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle driven by vga_sync_gen; frame_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             p_tick;
  logic [CNT_W-1:0] HCount;
  logic [CNT_W-1:0] VCount;
  logic             hsync;
  logic             vsync;
  logic             video_on;
`ifdef VGA_FRAME_TICK_EN
  logic             frame_tick;
`endif

  modport master (
    output p_tick, HCount, VCount, hsync, vsync, video_on
`ifdef VGA_FRAME_TICK_EN
    , output frame_tick
`endif
  );

  modport slave (
    input p_tick, HCount, VCount, hsync, vsync, video_on
`ifdef VGA_FRAME_TICK_EN
    , input frame_tick
`endif
  );
endinterface

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: div_cnt counts 0..PIX_DIV-1, p_tick marks its last value.
module vga_pixel_tick #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);
  // One bit is still kept for PIX_DIV=1 so the counter sits at 0 and p_tick stays high.
  localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;

  always_comb begin
    div_cnt_next = div_cnt_reg + DIV_W'(1);
    if (div_cnt_reg == DIV_LAST)
      div_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_next;
  end

  assign p_tick = (div_cnt_reg == DIV_LAST);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters with registered sync/visible flags decoded from the next-state counts.
// Optional start-of-frame pulse when VGA_FRAME_TICK_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = 2,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  logic             p_tick;
  logic [CNT_W-1:0] h_count_reg, h_count_next;
  logic [CNT_W-1:0] v_count_reg, v_count_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             video_on_reg, video_on_next;

  vga_pixel_tick #(.PIX_DIV(PIX_DIV)) u_pixel_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_tick (p_tick)
  );

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (p_tick) begin
      if (h_count_reg == H_LAST) begin
        h_count_next = '0;
        v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + CNT_W'(1);
      end else begin
        h_count_next = h_count_reg + CNT_W'(1);
      end
    end
    // Decoding the next counts keeps the flags aligned with the coordinates they accompany.
    hsync_next    = !((h_count_next >= HS_FIRST) && (h_count_next <= HS_LAST));
    vsync_next    = !((v_count_next >= VS_FIRST) && (v_count_next <= VS_LAST));
    video_on_next = (h_count_next < H_VIS) && (v_count_next < V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_reg  <= '0;
      v_count_reg  <= '0;
      hsync_reg    <= 1'b1;
      vsync_reg    <= 1'b1;
      video_on_reg <= 1'b1;
    end else begin
      h_count_reg  <= h_count_next;
      v_count_reg  <= v_count_next;
      hsync_reg    <= hsync_next;
      vsync_reg    <= vsync_next;
      video_on_reg <= video_on_next;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_reg;
  logic frame_tick_next;

  // Set only by the wrap out of the last pixel, so reset release never produces a pulse.
  assign frame_tick_next = p_tick && (h_count_reg == H_LAST) && (v_count_reg == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_tick_reg <= 1'b0;
    else
      frame_tick_reg <= frame_tick_next;
  end

  assign vga.frame_tick = frame_tick_reg;
`endif

  assign vga.p_tick   = p_tick;
  assign vga.HCount   = h_count_reg;
  assign vga.VCount   = v_count_reg;
  assign vga.hsync    = hsync_reg;
  assign vga.vsync    = vsync_reg;
  assign vga.video_on = video_on_reg;
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the system clock. It sits directly upstream of the figure-drawing stage and supplies the `HCount`/`VCount` pixel coordinates that stage consumes, plus `hsync`, `vsync`, a visible-area flag and a pixel-rate enable. The top level drives the monitor sync pins from this block and gates the drawing stage's `rgb` with `video_on`.

## Interface
Parameters:
- `PIX_DIV`, 2: clk cycles per pixel (2 gives 25 MHz pixels from 50 MHz clk); must be ≥1.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_DISP`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `p_tick`  out  1  pixel enable, high one clk in every `PIX_DIV`.
- `HCount`  out  10  horizontal pixel counter, 0..H_TOTAL-1.
- `VCount`  out  10  vertical line counter, 0..V_TOTAL-1.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `video_on`  out  1  high when `HCount<H_DISP && VCount<V_DISP`.
- `frame_tick`  out  1  start-of-frame pulse; present only with `VGA_FRAME_TICK_EN`.

## Operation
- Derived values: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both totals must fit in 10 bits.
- Divider `div_cnt` counts 0..PIX_DIV-1 and wraps. `p_tick` = (`div_cnt`==PIX_DIV-1). With PIX_DIV=1, `p_tick` is constantly 1.
- `HCount` increments on each clk edge where `p_tick`=1. At H_TOTAL-1 it wraps to 0.
- `VCount` increments only on the edge where `HCount` wraps. At V_TOTAL-1 it wraps to 0 at the same edge.
- `hsync`=0 iff HCount ∈ [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], i.e. 656..751.
- `vsync`=0 iff VCount ∈ [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1], i.e. 490..491.
- `hsync`, `vsync` and `video_on` are registered. They are computed from next-state counts, so they are always consistent with the `HCount`/`VCount` shown in the same cycle. They are glitch-free.
- Reset values: `div_cnt`=0, `HCount`=0, `VCount`=0, `hsync`=1, `vsync`=1, `video_on`=1 (consistent with 0,0), `frame_tick`=0. `p_tick` is 0 in reset for PIX_DIV>1, and 1 for PIX_DIV=1.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame restarts from (0,0) on release. No partial sync pulse is extended.

## Timing
- Counters and registered outputs change only on `p_tick` edges. Each value is held PIX_DIV clks.
- Line = H_TOTAL·PIX_DIV clks (1600). Frame = H_TOTAL·V_TOTAL·PIX_DIV clks (840 000).
- First `p_tick` occurs PIX_DIV clks after reset release. The first count change (HCount 0→1) happens at that edge.
- `hsync` low for H_SYNC·PIX_DIV clks (192). `vsync` low for V_SYNC·H_TOTAL·PIX_DIV clks (3200).
- Latency from coordinate to the drawing stage's `rgb`: 0 clks, since that stage is combinational.

## Configuration
- Macro: `VGA_FRAME_TICK_EN`.
- Defined: `frame_tick` port exists. It is registered and high for exactly one clk, in the first clk where (HCount,VCount)=(0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1). It is not asserted on reset release.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `vga_timing_pkg`: 640x480 default constants (H_DISP…V_BP), derived H_TOTAL/V_TOTAL, and the counter width constant (10).
- One sub-module: `vga_pixel_tick`, parameterised by PIX_DIV. It owns `div_cnt` and produces `p_tick`.
- Counter, sync-decode and output registers live in `vga_sync_gen`.

## Test plan
- Reset held, then released, with PIX_DIV=2 -> HCount=0, VCount=0, hsync=1, vsync=1, video_on=1, p_tick=0; first p_tick 2 clks after release, and HCount=1 after it.
- Run one line -> hsync falls when HCount=656, rises when HCount=752, and stays low 192 clks; HCount wraps 799→0 and VCount goes 0→1 on the same edge.
- video_on boundary -> 1 at (639,479); 0 at (640,479) and at (0,480); 1 again at (0,0) of the next frame.
- Full frame -> vsync low exactly while VCount ∈ {490,491} (3200 clks); frame period 840 000 clks; with `VGA_FRAME_TICK_EN`, frame_tick is high 1 clk, 840 000 clks apart.
- rst_n pulsed low asynchronously at (300,200) -> outputs return to reset values within the same clk; on release, counting restarts from (0,0) and the next vsync occurs at VCount=490.
- PIX_DIV=1 build -> p_tick constant 1; line = 800 clks; hsync low 96 clks.
